// File: rtl/ld_sd_mem_ctrl.sv
// Load/store data-memory controller: one outstanding req/gnt/rvalid access,
// store lane alignment, load realignment with sign/zero extension.
module ld_sd_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      lsu_clk,
    input  logic                      lsu_rst,
    input  logic                      wdt_reset_i,
    input  logic                      ld_valid_i,
    input  logic                      sd_valid_i,
    input  logic [DATA_WIDTH-1:0]     addr_i,
    input  logic [1:0]                byte_sel_i,
    input  logic                      sign_bit_i,
    input  logic [DATA_WIDTH-1:0]     sd_data_i,
    input  logic [GPR_ADDR_WIDTH-1:0] rd_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DATA_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    output logic [DATA_WIDTH-1:0]     ld_data_o,
    output logic                      ld_data_valid_o,
    output logic [GPR_ADDR_WIDTH-1:0] ld_rd_o,
    output logic                      stall_o,
    output logic                      misalign_exc_o,
    output logic                      bus_err_o,
    output logic [DATA_WIDTH-1:0]     exc_addr_o
);

    // state  | meaning
    // IDLE   | accepting a new ld/sd request
    // REQ    | mem_req_o high, waiting for grant
    // WAIT_R | load granted, waiting for read data
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_R = 2'd2} state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                      state_q, state_d;
    logic                        req_q, req_d;
    logic                        we_q, we_d;
    logic [DATA_WIDTH-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH/8-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [GPR_ADDR_WIDTH-1:0]   rd_q, rd_d;
    logic [1:0]                  size_q, size_d;
    logic                        sign_q, sign_d;
    logic [1:0]                  off_q, off_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]       ld_data_q, ld_data_d;
    logic                        ld_valid_q, ld_valid_d;
    logic [GPR_ADDR_WIDTH-1:0]   ld_rd_q, ld_rd_d;
    logic                        mis_q, mis_d;
    logic                        berr_q, berr_d;
    logic [DATA_WIDTH-1:0]       exc_q, exc_d;

    logic                        req_any;
    logic                        aligned;
    logic [DATA_WIDTH/8-1:0]     be_new;
    logic [DATA_WIDTH-1:0]       wdata_new;
    logic [DATA_WIDTH-1:0]       rsh;
    logic [DATA_WIDTH-1:0]       ext;

    assign req_any = ld_valid_i | sd_valid_i;

    always_comb begin
        aligned   = 1'b0;
        be_new    = 4'b1111;
        wdata_new = sd_data_i;
        case (byte_sel_i)
            2'b00: begin
                aligned   = 1'b1;
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{sd_data_i[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr_i[0];
                be_new    = 4'b0011 << addr_i[1:0];
                wdata_new = {2{sd_data_i[15:0]}};
            end
            2'b10:   aligned = (addr_i[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        rsh = mem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ext = {{24{sign_q & rsh[7]}}, rsh[7:0]};
            2'b01:   ext = {{16{sign_q & rsh[15]}}, rsh[15:0]};
            default: ext = rsh;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        size_d     = size_q;
        sign_d     = sign_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        ld_rd_d    = ld_rd_q;
        mis_d      = 1'b0;
        berr_d     = 1'b0;
        exc_d      = exc_q;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (!aligned) begin
                        mis_d = 1'b1;
                        exc_d = addr_i;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = ~ld_valid_i;
                        addr_d  = {addr_i[DATA_WIDTH-1:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        rd_d    = rd_i;
                        size_d  = byte_sel_i;
                        sign_d  = sign_bit_i;
                        off_d   = addr_i[1:0];
                        cnt_d   = 8'd0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    req_d = 1'b0;
                    cnt_d = 8'd0;
                    if (we_q) begin
                        state_d = IDLE;
                    end else if (mem_rvalid_i) begin
                        ld_data_d  = ext;
                        ld_valid_d = 1'b1;
                        ld_rd_d    = rd_q;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end else if (cnt_q == TO_LAST) begin
                    berr_d  = 1'b1;
                    exc_d   = {addr_q[DATA_WIDTH-1:2], off_q};
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    ld_data_d  = ext;
                    ld_valid_d = 1'b1;
                    ld_rd_d    = rd_q;
                    state_d    = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    berr_d  = 1'b1;
                    exc_d   = {addr_q[DATA_WIDTH-1:2], off_q};
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // soft reset wins over everything computed above
        if (wdt_reset_i) begin
            state_d    = IDLE;
            req_d      = 1'b0;
            we_d       = 1'b0;
            addr_d     = '0;
            be_d       = '0;
            wdata_d    = '0;
            rd_d       = '0;
            size_d     = 2'b00;
            sign_d     = 1'b0;
            off_d      = 2'b00;
            cnt_d      = 8'd0;
            ld_data_d  = '0;
            ld_valid_d = 1'b0;
            ld_rd_d    = '0;
            mis_d      = 1'b0;
            berr_d     = 1'b0;
            exc_d      = '0;
        end
    end

    always_ff @(posedge lsu_clk or posedge lsu_rst) begin
        if (lsu_rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            off_q      <= 2'b00;
            cnt_q      <= 8'd0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            ld_rd_q    <= '0;
            mis_q      <= 1'b0;
            berr_q     <= 1'b0;
            exc_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ld_rd_d;
            mis_q      <= mis_d;
            berr_q     <= berr_d;
            exc_q      <= exc_d;
        end
    end

    assign mem_req_o       = req_q;
    assign mem_we_o        = we_q;
    assign mem_addr_o      = addr_q;
    assign mem_be_o        = be_q;
    assign mem_wdata_o     = wdata_q;
    assign ld_data_o       = ld_data_q;
    assign ld_data_valid_o = ld_valid_q;
    assign ld_rd_o         = ld_rd_q;
    assign misalign_exc_o  = mis_q;
    assign bus_err_o       = berr_q;
    assign exc_addr_o      = exc_q;
    assign stall_o         = (state_q != IDLE) || (req_any && aligned);

endmodule

// File: tb/tb_ld_sd_mem_ctrl.sv
// Directed bench for ld_sd_mem_ctrl: transaction-level model compared every
// cycle, plus hand-computed checks for the documented scenarios.
module tb_ld_sd_mem_ctrl;

    localparam int TO = 4;

    logic        lsu_clk = 1'b0;
    logic        lsu_rst = 1'b1;
    logic        wdt_reset_i = 1'b0;
    logic        ld_valid_i = 1'b0, sd_valid_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [1:0]  byte_sel_i = '0;
    logic        sign_bit_i = 1'b0;
    logic [31:0] sd_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] ld_data_o;
    logic        ld_data_valid_o;
    logic [4:0]  ld_rd_o;
    logic        stall_o, misalign_exc_o, bus_err_o;
    logic [31:0] exc_addr_o;

    int n_vec = 0;
    int n_err = 0;

    ld_sd_mem_ctrl #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)) dut (
        .lsu_clk(lsu_clk), .lsu_rst(lsu_rst), .wdt_reset_i(wdt_reset_i),
        .ld_valid_i(ld_valid_i), .sd_valid_i(sd_valid_i), .addr_i(addr_i),
        .byte_sel_i(byte_sel_i), .sign_bit_i(sign_bit_i), .sd_data_i(sd_data_i),
        .rd_i(rd_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .ld_data_o(ld_data_o), .ld_data_valid_o(ld_data_valid_o), .ld_rd_o(ld_rd_o),
        .stall_o(stall_o), .misalign_exc_o(misalign_exc_o), .bus_err_o(bus_err_o),
        .exc_addr_o(exc_addr_o)
    );

    initial forever begin
        #5 lsu_clk = 1'b1;
        #5 lsu_clk = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_bytes(input logic [1:0] sel);
        return (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : (sel == 2'b10) ? 4 : 0;
    endfunction

    function automatic bit is_aligned(input logic [31:0] a, input logic [1:0] sel);
        int nb;
        nb = size_bytes(sel);
        return (nb != 0) && ((a % nb) == 0);
    endfunction

    function automatic logic [31:0] byte_mask(input int nb);
        return (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] d, input int nb);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i += nb) w = w | ((d & byte_mask(nb)) << (8 * i));
        return w;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] rdata, input int off,
                                           input int nb, input bit sgn);
        logic [31:0] v;
        v = (rdata >> (8 * off)) & byte_mask(nb);
        if (sgn && (((v >> (8 * nb - 1)) & 32'd1) != 0)) v = v | ~byte_mask(nb);
        return v;
    endfunction

    int          m_phase = 0;   // 0 free, 1 awaiting grant, 2 awaiting read data
    int          m_wait = 0;
    int          m_nb = 0, m_off = 0;
    bit          m_sgn = 0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_baddr = '0;
    logic        e_req = 0, e_we = 0, e_ld_valid = 0, e_mis = 0, e_berr = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_ld_data = '0, e_exc = '0;
    logic [3:0]  e_be = '0;
    logic [4:0]  e_ld_rd = '0;

    always @(posedge lsu_clk or posedge lsu_rst) begin : model
        int nb;
        if (lsu_rst || wdt_reset_i) begin
            m_phase <= 0; m_wait <= 0; m_nb <= 0; m_off <= 0; m_sgn <= 0;
            m_rd <= '0; m_baddr <= '0;
            e_req <= 0; e_we <= 0; e_ld_valid <= 0; e_mis <= 0; e_berr <= 0;
            e_addr <= '0; e_wdata <= '0; e_ld_data <= '0; e_exc <= '0;
            e_be <= '0; e_ld_rd <= '0;
        end else begin
            e_ld_valid <= 0;
            e_mis      <= 0;
            e_berr     <= 0;
            if (m_phase == 0) begin
                if (ld_valid_i || sd_valid_i) begin
                    nb = size_bytes(byte_sel_i);
                    if (!is_aligned(addr_i, byte_sel_i)) begin
                        e_mis <= 1;
                        e_exc <= addr_i;
                    end else begin
                        e_req   <= 1;
                        e_we    <= !ld_valid_i;
                        e_addr  <= addr_i & ~32'd3;
                        e_be    <= 4'(((1 << nb) - 1) << (addr_i % 4));
                        e_wdata <= replicate(sd_data_i, nb);
                        m_nb    <= nb;
                        m_off   <= int'(addr_i % 4);
                        m_sgn   <= sign_bit_i;
                        m_rd    <= rd_i;
                        m_baddr <= addr_i;
                        m_wait  <= 0;
                        m_phase <= 1;
                    end
                end
            end else if (m_phase == 1 && mem_gnt_i) begin
                e_req  <= 0;
                m_wait <= 0;
                if (e_we) m_phase <= 0;
                else if (mem_rvalid_i) begin
                    e_ld_data  <= extend(mem_rdata_i, m_off, m_nb, m_sgn);
                    e_ld_valid <= 1;
                    e_ld_rd    <= m_rd;
                    m_phase    <= 0;
                end else m_phase <= 2;
            end else if (m_phase == 2 && mem_rvalid_i) begin
                e_ld_data  <= extend(mem_rdata_i, m_off, m_nb, m_sgn);
                e_ld_valid <= 1;
                e_ld_rd    <= m_rd;
                m_phase    <= 0;
            end else if (m_wait + 1 == TO) begin
                e_berr  <= 1;
                e_exc   <= m_baddr;
                e_req   <= 0;
                m_phase <= 0;
            end else begin
                m_wait <= m_wait + 1;
            end
        end
    end

    always @(negedge lsu_clk) begin
        chk("mem_req", mem_req_o, e_req);
        chk("mem_we", mem_we_o, e_we);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_be", mem_be_o, e_be);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("ld_data", ld_data_o, e_ld_data);
        chk("ld_valid", ld_data_valid_o, e_ld_valid);
        chk("ld_rd", ld_rd_o, e_ld_rd);
        chk("misalign", misalign_exc_o, e_mis);
        chk("bus_err", bus_err_o, e_berr);
        chk("exc_addr", exc_addr_o, e_exc);
        chk("stall", stall_o, (m_phase != 0) ||
            ((ld_valid_i || sd_valid_i) && is_aligned(addr_i, byte_sel_i)));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge lsu_clk);
        #1;
    endtask

    task automatic req(input bit ld, input bit sd, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] d, input bit sg,
                       input logic [4:0] r);
        ld_valid_i = ld; sd_valid_i = sd; byte_sel_i = sel; addr_i = a;
        sd_data_i = d; sign_bit_i = sg; rd_i = r;
    endtask

    task automatic idle_in();
        ld_valid_i = 0;
        sd_valid_i = 0;
    endtask

    initial begin
        bit seen;
        repeat (3) tick();
        lsu_rst = 1'b0;
        tick(); #1;
        chk("rst_stall", stall_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_ld_data", ld_data_o, 0);

        // sb at 0x1003, immediate grant
        mem_gnt_i = 1;
        req(0, 1, 2'b00, 32'h1003, 32'h0000_00A5, 0, 0); #1;
        chk("sb_stall_c0", stall_o, 1);
        tick(); idle_in(); #1;
        chk("sb_req", mem_req_o, 1);
        chk("sb_addr", mem_addr_o, 32'h1000);
        chk("sb_be", mem_be_o, 4'b1000);
        chk("sb_wdata", mem_wdata_o, 32'hA5A5_A5A5);
        chk("sb_we", mem_we_o, 1);
        chk("sb_stall_c1", stall_o, 1);
        tick(); #1;
        chk("sb_stall_c2", stall_o, 0);
        chk("sb_req_c2", mem_req_o, 0);

        // lh signed / unsigned at 0x2002
        for (int s = 1; s >= 0; s--) begin
            tick(); req(1, 0, 2'b01, 32'h2002, 0, s[0], 7);
            tick(); idle_in();
            tick(); mem_rvalid_i = 1; mem_rdata_i = 32'h80FF_1234;
            tick(); mem_rvalid_i = 0; #1;
            chk("lh_valid", ld_data_valid_o, 1);
            chk("lh_data", ld_data_o, (s == 1) ? 32'hFFFF_80FF : 32'h0000_80FF);
            chk("lh_rd", ld_rd_o, 7);
            tick(); #1;
            chk("lh_valid_pulse", ld_data_valid_o, 0);
        end

        // misaligned lw, then illegal size
        tick(); req(1, 0, 2'b10, 32'h3001, 0, 0, 1); #1;
        chk("mis_stall_c0", stall_o, 0);
        tick(); idle_in(); #1;
        chk("mis_pulse", misalign_exc_o, 1);
        chk("mis_exc", exc_addr_o, 32'h3001);
        chk("mis_noreq", mem_req_o, 0);
        tick(); #1;
        chk("mis_pulse_end", misalign_exc_o, 0);
        tick(); req(0, 1, 2'b11, 32'h3008, 32'h55, 0, 0);
        tick(); idle_in(); #1;
        chk("ill_pulse", misalign_exc_o, 1);
        chk("ill_exc", exc_addr_o, 32'h3008);
        chk("ill_noreq", mem_req_o, 0);

        // grant timeout, then an sb accepted immediately after
        tick(); mem_gnt_i = 0; req(1, 0, 2'b00, 32'h4001, 0, 0, 2);
        tick(); idle_in();
        repeat (3) tick();
        #1;
        chk("to_req_c4", mem_req_o, 1);
        chk("to_berr_c4", bus_err_o, 0);
        tick(); #1;
        chk("to_berr", bus_err_o, 1);
        chk("to_req_drop", mem_req_o, 0);
        chk("to_stall", stall_o, 0);
        chk("to_exc", exc_addr_o, 32'h4001);
        mem_gnt_i = 1;
        req(0, 1, 2'b00, 32'h5002, 32'h0000_003C, 0, 0); #1;
        chk("to_next_stall", stall_o, 1);
        tick(); idle_in(); #1;
        chk("to_next_req", mem_req_o, 1);
        chk("to_next_addr", mem_addr_o, 32'h5000);
        chk("to_next_be", mem_be_o, 4'b0100);
        chk("to_next_wdata", mem_wdata_o, 32'h3C3C_3C3C);

        // read-data timeout
        tick(); req(1, 0, 2'b10, 32'h9000, 0, 0, 4);
        tick(); idle_in();
        seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick(); #1;
            if (bus_err_o) seen = 1;
        end
        chk("rto_seen", seen, 1);
        chk("rto_exc", exc_addr_o, 32'h9000);

        // ld and sd together: load wins
        tick(); req(1, 1, 2'b10, 32'h6000, 32'hDEAD_BEEF, 0, 3);
        tick(); idle_in(); #1;
        chk("both_we", mem_we_o, 0);
        chk("both_req", mem_req_o, 1);
        tick(); mem_rvalid_i = 1; mem_rdata_i = 32'h1122_3344;
        tick(); mem_rvalid_i = 0; #1;
        chk("both_valid", ld_data_valid_o, 1);
        chk("both_data", ld_data_o, 32'h1122_3344);
        chk("both_rd", ld_rd_o, 3);

        // sw then lbu held under stall; rvalid arrives with grant
        tick(); req(0, 1, 2'b10, 32'h7000, 32'hCAFE_F00D, 0, 0);
        tick(); req(1, 0, 2'b00, 32'h7003, 0, 0, 12);
        mem_rvalid_i = 1; mem_rdata_i = 32'hAB00_0000; #1;
        chk("b2b_sw_be", mem_be_o, 4'b1111);
        chk("b2b_sw_wdata", mem_wdata_o, 32'hCAFE_F00D);
        chk("b2b_sw_we", mem_we_o, 1);
        for (int k = 0; k < 10 && m_phase != 0; k++) tick();
        tick(); idle_in();
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick(); #1;
            if (ld_data_valid_o) seen = 1;
        end
        mem_rvalid_i = 0;
        chk("b2b_lbu_seen", seen, 1);
        chk("b2b_lbu_data", ld_data_o, 32'h0000_00AB);
        chk("b2b_lbu_rd", ld_rd_o, 12);

        // async reset during WAIT_R
        tick(); req(1, 0, 2'b10, 32'hA000, 0, 0, 5);
        tick(); idle_in();
        tick(); lsu_rst = 1; #1;
        chk("arst_req", mem_req_o, 0);
        chk("arst_addr", mem_addr_o, 0);
        chk("arst_wdata", mem_wdata_o, 0);
        chk("arst_exc", exc_addr_o, 0);
        chk("arst_ld_data", ld_data_o, 0);
        chk("arst_stall", stall_o, 0);
        tick(); tick(); lsu_rst = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
        tick(); #1;
        chk("arst_no_ldv1", ld_data_valid_o, 0);
        tick(); #1;
        chk("arst_no_ldv2", ld_data_valid_o, 0);
        mem_rvalid_i = 0;

        // synchronous soft reset during WAIT_R
        tick(); req(1, 0, 2'b10, 32'h8000, 0, 0, 9);
        tick(); idle_in();
        tick(); wdt_reset_i = 1; #1;
        chk("wdt_hold_addr", mem_addr_o, 32'h8000);
        chk("wdt_hold_stall", stall_o, 1);
        tick(); wdt_reset_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0BAD_F00D; #1;
        chk("wdt_addr", mem_addr_o, 0);
        chk("wdt_stall", stall_o, 0);
        chk("wdt_ld_rd", ld_rd_o, 0);
        chk("wdt_exc", exc_addr_o, 0);
        tick(); #1;
        chk("wdt_no_ldv", ld_data_valid_o, 0);
        mem_rvalid_i = 0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ld_sd_mem_ctrl.md
Name: ld_sd_mem_ctrl

Overview:
- Downstream of the load/store address generator.
- Consumes the registered effective address, byte enable class, sign control and ld/sd valid strobes, and drives a single-outstanding request/grant/rvalid data-memory port.
- Lane-aligns store data and byte enables; realigns and sign/zero-extends load data for writeback.
- Stalls the pipeline while an access is in flight; flags misaligned accesses and bus timeouts.

Parameters:
- DATA_WIDTH, 32, data/address width; only 32 supported (4 byte lanes).
- GPR_ADDR_WIDTH, 5, destination register index width.
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_gnt_i or mem_rvalid_i; 1..255 (8-bit counter).

Ports:
- lsu_clk  in  1  clock; all state on rising edge.
- lsu_rst  in  1  reset.
- wdt_reset_i  in  1  synchronous soft reset; same values as lsu_rst.
- ld_valid_i  in  1  load request from address stage.
- sd_valid_i  in  1  store request from address stage.
- addr_i  in  DATA_WIDTH  effective byte address.
- byte_sel_i  in  2  size: 00 byte, 01 half, 10 word, 11 illegal.
- sign_bit_i  in  1  1 = sign-extend load, 0 = zero-extend.
- sd_data_i  in  DATA_WIDTH  store data, LSB-justified.
- rd_i  in  GPR_ADDR_WIDTH  load destination register.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  DATA_WIDTH  word-aligned address (addr_i with [1:0] = 0).
- mem_be_o  out  DATA_WIDTH/8  lane byte enables.
- mem_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_WIDTH  read word.
- ld_data_o  out  DATA_WIDTH  extended load result.
- ld_data_valid_o  out  1  one-cycle writeback strobe.
- ld_rd_o  out  GPR_ADDR_WIDTH  destination for ld_data_o.
- stall_o  out  1  hold upstream pipeline.
- misalign_exc_o  out  1  one-cycle misaligned/illegal-size pulse.
- bus_err_o  out  1  one-cycle timeout pulse.
- exc_addr_o  out  DATA_WIDTH  faulting byte address, held until the next fault.

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-high: lsu_clk, lsu_rst.
- lsu_rst or wdt_reset_i: state IDLE; all outputs and internal registers 0.
- Reset mid-transaction aborts the access; mem_req_o falls immediately on lsu_rst, and no late rvalid is reported.

States:
- IDLE, REQ, WAIT_R.

IDLE:
- Samples a request: ld_valid_i has priority if both ld_valid_i and sd_valid_i are high.
- Misaligned access (half with addr_i[0]=1, word with addr_i[1:0]!=0, or byte_sel_i=11):
  - misalign_exc_o pulses next cycle, exc_addr_o <= addr_i.
  - No bus request; stay in IDLE.
- Otherwise latch mem_addr_o, mem_be_o, mem_wdata_o, mem_we_o (=store), rd, size, sign and addr[1:0]; assert mem_req_o next cycle; go to REQ.

Lane rules (off = addr_i[1:0]):
- Byte: be = 0001 << off; wdata = {4{sd_data_i[7:0]}}.
- Half: be = 0011 << off; wdata = {2{sd_data_i[15:0]}}.
- Word: be = 1111; wdata = sd_data_i.

REQ:
- mem_req_o and all mem_* outputs held stable until mem_gnt_i.
- On grant, mem_req_o drops next cycle.
- Store: done, go to IDLE.
- Load: go to WAIT_R.

WAIT_R:
- On mem_rvalid_i: sh = mem_rdata_i >> (8*off), extend bit 7/15/31 per size and sign.
- Next cycle: ld_data_o updated, ld_data_valid_o = 1 for one cycle, ld_rd_o = latched rd; go to IDLE.
- Grant and rvalid in the same cycle while in REQ: treated as grant followed by rvalid; data is captured that cycle, no loss.

Timeout:
- 8-bit counter cleared on entry to REQ/WAIT_R; increments each waiting cycle.
- At TIMEOUT_CYCLES: bus_err_o pulses, exc_addr_o <= latched address, mem_req_o drops, go to IDLE.

stall_o:
- High when state != IDLE, or combinationally when in IDLE with an aligned valid request.
- Low on the cycle the FSM returns to IDLE.
- Requests while not IDLE are ignored; upstream holds them because of stall_o.

Latency:
- Store with 0-wait grant: 2 cycles of stall.
- Load with 0-wait grant and rvalid next cycle: ld_data_valid_o 3 cycles after request.

Test Plan:
- Store: sb, addr_i=0x1003, sd_data_i=0x000000A5, gnt immediate -> mem_addr_o=0x1000, mem_be_o=1000, mem_wdata_o=0xA5A5A5A5, mem_we_o=1, stall 2 cycles.
- Load: lh signed, addr_i=0x2002, rdata=0x80FF1234, rd_i=7 -> ld_data_o=0xFFFF80FF, ld_rd_o=7, one-cycle ld_data_valid_o; repeat with sign_bit_i=0 -> 0x000080FF.
- Misaligned: lw at 0x3001 -> no mem_req_o, misalign_exc_o one pulse, exc_addr_o=0x3001; byte_sel_i=11 gives the same result.
- Timeout: TIMEOUT_CYCLES=4, load never granted -> bus_err_o after 4 waiting cycles, mem_req_o low, stall_o low, FSM accepts a new sb next cycle.
- Simultaneous and back-to-back: ld_valid_i and sd_valid_i both high -> load performed only; sw then lbu back-to-back with stall honoured -> both complete in order.
- Reset: assert lsu_rst during WAIT_R, then rvalid -> all outputs 0 asynchronously, no ld_data_valid_o; same with wdt_reset_i (synchronous).
